ram_sum_ctrl: RTL and testbench

- FSM plus datapath that sits directly downstream of the team's 16-word asynchronous-read RAM. It drives that RAM's address input and consumes its data output.
- On a start request it walks addresses 0..N-1 and accumulates the words into a running sum.
- It reports the result with a done flag.
- This is the control/datapath half of the lab 4/5 array-sum design.

---
 rtl/ram_sum_ctrl_if.sv | 41 ++++
 rtl/ram_sum_ctrl.sv | 134 +++++++++++++
 tb/tb_ram_sum_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sum_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_sum_ctrl_if
// Purpose  : Bundles the request/result handshake and the RAM address/data
//            pair used by ram_sum_ctrl.
// Signals  : start  - level-sampled run request
//            count  - number of words to sum (sampled with start)
//            addr   - address driven toward the asynchronous-read RAM
//            rdata  - RAM read data for the current addr (same cycle)
//            sum    - accumulated result
//            busy   - run in progress
//            done   - result valid
//            ovf    - sticky overflow flag (saturating build only)
// Modports : master - requester / RAM side
//            slave  - ram_sum_ctrl
// Revision : 1.0 - initial release
// ============================================================================
interface ram_sum_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
);
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] sum;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output start, count, rdata,
    input  addr, sum, busy, done, ovf
  );

  modport slave (
    input  start, count, rdata,
    output addr, sum, busy, done, ovf
  );
endinterface
`default_nettype wire

// File: rtl/ram_sum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_sum_ctrl
// Purpose  : Walks addresses 0..N-1 of a DEPTH-word asynchronous-read RAM and
//            accumulates the words into a running sum, then flags done.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - ram_sum_ctrl_if.slave (start, count, rdata in;
//                   addr, sum, busy, done, ovf out)
// Options  : RAM_SUM_SAT_EN - when defined, the accumulator saturates at
//            all-ones and raises a sticky ovf; otherwise it wraps and ovf
//            is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module ram_sum_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input logic           clk,
  input logic           rst,
  ram_sum_ctrl_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);
  localparam logic [AW-1:0]    c_addr_last = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_addr;
  logic [AW-1:0]    w_addr_nxt;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_nxt;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_remaining_nxt;
  logic [CNT_W-1:0] w_n;
  logic [WIDTH-1:0] w_acc;

  // Requested length, clamped so the walk never leaves the RAM.
  assign w_n = (bus.count > c_depth_cnt) ? c_depth_cnt : bus.count;

`ifdef RAM_SUM_SAT_EN
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic [WIDTH:0]   w_wide;
  logic             w_acc_ovf;

  // Once the sum is all-ones, any further add either carries out or adds
  // zero, so saturation holds for the rest of the run without extra state.
  assign w_wide    = {1'b0, r_sum} + {1'b0, bus.rdata};
  assign w_acc_ovf = w_wide[WIDTH];
  assign w_acc     = w_wide[WIDTH] ? {WIDTH{1'b1}} : w_wide[WIDTH-1:0];
  assign bus.ovf   = r_ovf;
`else
  assign w_acc   = r_sum + bus.rdata;
  assign bus.ovf = 1'b0;
`endif

  // Next-state and datapath decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_sum_nxt       = r_sum;
    w_remaining_nxt = r_remaining;
`ifdef RAM_SUM_SAT_EN
    w_ovf_nxt       = r_ovf;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_sum_nxt  = '0;
          w_addr_nxt = '0;
`ifdef RAM_SUM_SAT_EN
          w_ovf_nxt  = 1'b0;
`endif
          w_remaining_nxt = w_n;
          w_state_nxt     = (w_n == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_sum_nxt       = w_acc;
        w_remaining_nxt = r_remaining - CNT_W'(1);
`ifdef RAM_SUM_SAT_EN
        w_ovf_nxt       = r_ovf | w_acc_ovf;
`endif
        // A full-depth run would step past the last word; hold there so the
        // RAM is never addressed out of range.
        if (r_addr != c_addr_last) begin
          w_addr_nxt = r_addr + AW'(1);
        end
        if (r_remaining == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_sum       <= '0;
      r_remaining <= '0;
`ifdef RAM_SUM_SAT_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_sum       <= w_sum_nxt;
      r_remaining <= w_remaining_nxt;
`ifdef RAM_SUM_SAT_EN
      r_ovf       <= w_ovf_nxt;
`endif
    end
  end

  assign bus.addr = {{(WIDTH - AW){1'b0}}, r_addr};
  assign bus.sum  = r_sum;
  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ram_sum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_sum_ctrl
// Purpose  : Self-checking bench for ram_sum_ctrl. A driver issues runs and
//            queues the expected result (sum, ovf, final addr, done edge);
//            a monitor pops and compares each time a result is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_sum_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             ovf;
    logic [WIDTH-1:0] addr;
    int               edge_n;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] mem [DEPTH];
  int               n_edges;
  int               checks;
  int               errors;
  exp_t             sb [$];

  ram_sum_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  ram_sum_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Asynchronous-read RAM model; out-of-range reads return a marker value.
  assign bus.rdata = (bus.addr < WIDTH'(DEPTH)) ? mem[bus.addr[3:0]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial n_edges = 0;
  always @(posedge clk) n_edges++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, n_edges);
    end
  endtask

  // Reference: plain sum of the first n words, then wrap or saturate.
  function automatic void ref_model(input int n, output logic [WIDTH-1:0] s, output logic o);
    longint unsigned acc;
    acc = 0;
    for (int i = 0; i < n; i++) acc += longint'(mem[i]);
`ifdef RAM_SUM_SAT_EN
    if (acc > 64'h0000_0000_FFFF_FFFF) begin
      s = '1;
      o = 1'b1;
    end else begin
      s = acc[31:0];
      o = 1'b0;
    end
`else
    s = acc[31:0];
    o = 1'b0;
`endif
  endfunction

  function automatic exp_t make_exp(input int cnt, input int accept_edge);
    exp_t e;
    int   n;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    ref_model(n, e.sum, e.ovf);
    e.addr   = (n == DEPTH) ? WIDTH'(DEPTH - 1) : WIDTH'(n);
    e.edge_n = accept_edge + n;
    return e;
  endfunction

  task automatic load_ramp();
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i + 1);
  endtask

  // Single start pulse; the DUT must be in IDLE or DONE.
  task automatic issue(input int cnt);
    @(negedge clk);
    sb.push_back(make_exp(cnt, n_edges + 1));
    bus.start = 1'b1;
    bus.count = CNT_W'(cnt);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // start held high for k consecutive runs.
  task automatic issue_held(input int cnt, input int k);
    int e0;
    int n;
    int t;
    @(negedge clk);
    n  = (cnt > DEPTH) ? DEPTH : cnt;
    e0 = n_edges + 1;
    for (int i = 0; i < k; i++) sb.push_back(make_exp(cnt, e0 + i * (n + 1)));
    bus.start = 1'b1;
    bus.count = CNT_W'(cnt);
    t = 0;
    while (n_edges != e0 + k * (n + 1) - 1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    bus.start = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge, once inputs for the
  // next rising edge are settled.
  initial begin : monitor
    logic prev_done;
    logic prev_accept;
    int   run_idx;
    exp_t e;
    prev_done   = 1'b0;
    prev_accept = 1'b0;
    run_idx     = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_done   = 1'b0;
        prev_accept = 1'b0;
        run_idx     = 0;
      end else begin
        if (prev_accept) run_idx = 0;
        if (bus.busy) begin
          chk("run_addr", 64'(bus.addr), 64'(run_idx));
          run_idx++;
        end
        if (bus.done && (!prev_done || prev_accept)) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: result with sum 0x%0h, expected none", bus.sum);
          end else begin
            e = sb.pop_front();
            chk("sum", 64'(bus.sum), 64'(e.sum));
            chk("ovf", 64'(bus.ovf), 64'(e.ovf));
            chk("final_addr", 64'(bus.addr), 64'(e.addr));
            chk("done_edge", 64'(n_edges), 64'(e.edge_n));
          end
        end
        prev_done   = bus.done;
        prev_accept = bus.start && !bus.busy;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int cnt;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.count = '0;
    load_ramp();

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_addr", 64'(bus.addr), 64'd0);
    chk("rst_sum",  64'(bus.sum),  64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_ovf",  64'(bus.ovf),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ramp RAM: short, full, clamped and empty runs.
    issue(4);  wait_drain();
    issue(16); wait_drain();
    issue(20); wait_drain();
    issue(0);  wait_drain();

    // start re-asserted mid-run is ignored; then back-to-back from DONE.
    issue(8);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.count = CNT_W'(2);
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    issue(2); wait_drain();

    // start held high: one single-cycle done per run.
    issue_held(3, 3);
    wait_drain();

    // Asynchronous reset in the middle of a full run.
    issue(16);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_addr", 64'(bus.addr), 64'd0);
    chk("mid_rst_sum",  64'(bus.sum),  64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    issue(3); wait_drain();

    // All-ones words: wrap or saturate, then a clean run clears ovf.
    for (int i = 0; i < DEPTH; i++) mem[i] = '1;
    issue(2); wait_drain();
    issue(16); wait_drain();
    load_ramp();
    issue(1); wait_drain();

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] = ($urandom_range(0, 2) == 0) ? (32'hF000_0000 | $urandom) : $urandom;
      end
      cnt = $urandom_range(0, 20);
      issue(cnt);
      wait_drain();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
